regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file with a per-register busy scoreboard.

---
 rtl/regfile_mp_pkg.sv | 6 +
 rtl/regfile_mp_scoreboard.sv | 37 +++
 rtl/regfile_mp.sv | 77 +++++++
 tb/tb_regfile_mp.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file and its busy scoreboard.
package regfile_mp_pkg;
  localparam int unsigned REGFILE_ZERO_ADDR = 0;
  localparam int unsigned REGFILE_XLEN_DEF  = 32;
  localparam int unsigned REGFILE_NREGS_DEF = 32;
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits: set by a reservation, cleared by a committed writeback.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NREGS = REGFILE_NREGS_DEF,
  parameter int unsigned NWR   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NREGS-1:0]  busy,
  output logic              rsv_ok
);
  logic [NREGS-1:0] busy_d;

  // Reservation is applied after the clears so a same-cycle reserve keeps the register busy.
  always_comb begin
    busy_d = busy;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (we[w] && waddr[w*AW +: AW] != AW'(REGFILE_ZERO_ADDR))
        busy_d[waddr[w*AW +: AW]] = 1'b0;
    end
    if (rsv_valid && rsv_addr != AW'(REGFILE_ZERO_ADDR))
      busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

  assign rsv_ok = (rsv_addr == AW'(REGFILE_ZERO_ADDR)) || !busy[rsv_addr];
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, x0 hardwired to zero, with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle committed writes to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN  = REGFILE_XLEN_DEF,
  parameter int unsigned NREGS = REGFILE_NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]       rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic [NWR-1:0]            we,
  input  logic [NWR*$clog2(NREGS)-1:0] waddr,
  input  logic [NWR*XLEN-1:0]       wdata,
  input  logic                      rsv_valid,
  input  logic [$clog2(NREGS)-1:0]  rsv_addr,
  output logic                      rsv_ok
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    ra [NRD];

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy      (busy),
    .rsv_ok    (rsv_ok)
  );

  // Ports are applied in index order so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (we[w] && waddr[w*AW +: AW] != AW'(REGFILE_ZERO_ADDR))
          mem[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra[p] = rd_addr[p*AW +: AW];
      rd_data[p*XLEN +: XLEN] = mem[ra[p]];
      rd_busy[p] = busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned w = 0; w < NWR; w++) begin
        if (we[w] && waddr[w*AW +: AW] == ra[p]) begin
          rd_data[p*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
          rd_busy[p] = 1'b0;
        end
      end
`endif
      if (ra[p] == AW'(REGFILE_ZERO_ADDR)) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed cases plus a random shadow-model run.
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*XLEN-1:0]  wdata;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic                 rsv_ok;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid),
    .rsv_addr(rsv_addr), .rsv_ok(rsv_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input int a);
    logic [XLEN-1:0] d;
    if (a == 0) return '0;
    d = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (we[w] && int'(waddr[w*AW +: AW]) == a) d = wdata[w*XLEN +: XLEN];
`endif
    return d;
  endfunction

  function automatic bit exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (we[w] && int'(waddr[w*AW +: AW]) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // Compare every output against the model, then advance DUT and model one clock.
  task automatic tick();
    #1;
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("rd_data%0d", p), rd_data[p*XLEN +: XLEN], exp_data(int'(rd_addr[p*AW +: AW])));
      check($sformatf("rd_busy%0d", p), 32'(rd_busy[p]), 32'(exp_busy(int'(rd_addr[p*AW +: AW]))));
    end
    check("rsv_ok", 32'(rsv_ok), 32'((rsv_addr == 0) || !m_busy[rsv_addr]));
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        int a = int'(waddr[w*AW +: AW]);
        if (we[w] && a != 0) begin m_reg[a] = wdata[w*XLEN +: XLEN]; m_busy[a] = 1'b0; end
      end
      if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; we = '0; waddr = '0; wdata = '0; rsv_valid = 0; rsv_addr = '0;
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    we[port] = 1'b1;
    waddr[port*AW +: AW] = AW'(a);
    wdata[port*XLEN +: XLEN] = d;
  endtask

  task automatic expect_read(input string tag, input int a, input logic [31:0] d, input bit b);
    rd_addr[AW-1:0] = AW'(a);
    #1;
    check({tag, "_data"}, rd_data[XLEN-1:0], d);
    check({tag, "_busy"}, 32'(rd_busy[0]), 32'(b));
  endtask

  initial begin
    idle();
    rd_addr = '0;
    rst = 1;
    @(negedge clk);
    tick();
    idle();

    // 1: random writes, then reset clears everything
    for (int i = 0; i < 6; i++) begin
      wr(0, $urandom_range(1, 31), $urandom); wr(1, $urandom_range(1, 31), $urandom);
      rsv_valid = 1; rsv_addr = AW'($urandom_range(1, 31));
      tick();
    end
    idle(); rst = 1; tick(); idle();
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {AW'(0), AW'(a)};
      tick();
      check("reset_zero", rd_data[XLEN-1:0], 32'h0);
    end

    // 2: simple write, visible next cycle
    wr(0, 5, 32'hDEADBEEF); tick(); idle();
    expect_read("t2", 5, 32'hDEADBEEF, 0);

    // 3: x0 ignores writes and reservations
    wr(0, 0, 32'hFFFFFFFF); rsv_valid = 1; rsv_addr = '0; tick(); idle();
    expect_read("t3", 0, 32'h0, 0);
    check("t3_rsv_ok", 32'(rsv_ok), 32'h1);

    // 4: write-port collision, port 1 wins
    wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); tick(); idle();
    expect_read("t4", 7, 32'h2222, 0);

    // 5: reservation lifecycle on x9
    rsv_valid = 1; rsv_addr = 9; tick(); idle();
    rsv_addr = 9;
    expect_read("t5a", 9, 32'h0, 1);
    check("t5a_rsv_ok", 32'(rsv_ok), 32'h0);
    wr(0, 9, 32'h99); rsv_valid = 1; rsv_addr = 9; tick(); idle();
    expect_read("t5b", 9, 32'h99, 1);
    wr(0, 9, 32'h98); tick(); idle();
    expect_read("t5c", 9, 32'h98, 0);

    // busy is a flag, not a count
    rsv_valid = 1; rsv_addr = 10; tick(); tick(); idle();
    wr(1, 10, 32'hA0); tick(); idle();
    expect_read("t5d", 10, 32'hA0, 0);

    // 6: same-cycle write/read of x3
    wr(0, 3, 32'h1234); tick(); idle();
    wr(0, 3, 32'hABCD);
`ifdef REGFILE_BYPASS_EN
    expect_read("t6a", 3, 32'hABCD, 0);
`else
    expect_read("t6a", 3, 32'h1234, 0);
`endif
    tick(); idle();
    expect_read("t6b", 3, 32'hABCD, 0);

    // random shadow-model run; narrow address range half the time to force collisions
    for (int i = 0; i < 10000; i++) begin
      int hi = ($urandom_range(0, 1) == 0) ? 7 : 31;
      rst = ($urandom_range(0, 299) == 0);
      we = NWR'($urandom);
      for (int w = 0; w < NWR; w++) begin
        waddr[w*AW +: AW] = AW'($urandom_range(0, hi));
        wdata[w*XLEN +: XLEN] = $urandom;
      end
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, hi));
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, hi));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
